// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform generator with wrap-aligned retune, phase offset/sync,
// five waveforms and Q1 gain with saturation; 3-stage output pipeline behind the accumulator.
module dds_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int OUT_W = 16,
  parameter int LUT_AW = 8,
  parameter int AMP_W = 16,
  parameter bit APPLY_AT_WRAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  input  logic               phase_sync,
  input  logic               tune_load,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [2:0]         wave_sel,
  input  logic [OUT_W-1:0]   duty,
  input  logic [AMP_W-1:0]   amp,
  output logic [OUT_W-1:0]   wave_o,
  output logic               valid_o,
  output logic               wrap_o
);
  localparam int KW = (OUT_W > LUT_AW + 2) ? OUT_W : LUT_AW + 2;
  localparam int PW = OUT_W + AMP_W + 1;
  localparam logic [OUT_W-1:0] MSB = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS = ~MSB;
  localparam logic [OUT_W-1:0] NEG = MSB | OUT_W'(1);
  localparam logic signed [PW-1:0] Y_MAX = {{(AMP_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] Y_MIN = {{(AMP_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [PHASE_W-1:0] acc_q, acc_d, tw_active_q, tw_active_d, tw_pending_q, tw_pending_d, ps;
  logic [PHASE_W:0]   sum;
  logic               pend_q, pend_d, wrap_q, wrap_d, apply;
  logic [KW-1:0]      p_q, p_d;
  logic [2:0]         sel_q, sel_d, vld_q, vld_d;
  logic [OUT_W-1:0]   duty_q, duty_d, raw_q, raw_d, wave_q, wave_d;
  logic [OUT_W-1:0]   u, saw, tri_w, rect, mag, sine;
  logic [AMP_W-1:0]   amp1_q, amp1_d, amp2_q, amp2_d;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;
  logic [OUT_W-2:0]   t;
  logic signed [PW-1:0] prod, y;
  logic [OUT_W-1:0]   rom [2**LUT_AW];
  logic               unused_lo;

  // Quarter-wave table sampled at bin centres so the mirrored quadrants stay exactly symmetric
  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    assign rom[i] = OUT_W'($rtoi((2.0 ** (OUT_W-1) - 1.0) *
                    $sin(3.14159265358979 * (i + 0.5) / (2.0 ** (LUT_AW+1))) + 0.5));
  end

  assign unused_lo = ^ps[PHASE_W-KW-1:0];

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, tw_active_q};
    wrap_d = !phase_sync && !halt && sum[PHASE_W];
    acc_d = phase_sync ? '0 : (halt ? acc_q : sum[PHASE_W-1:0]);
    // A word loaded this cycle is not eligible yet; only the older pending word can apply
    apply = pend_q && (!APPLY_AT_WRAP || tw_active_q == '0 || phase_sync || wrap_d);
    tw_active_d = apply ? tw_pending_q : tw_active_q;
    tw_pending_d = tune_load ? tune_word : tw_pending_q;
    pend_d = tune_load || (pend_q && !apply);
    ps = acc_q + phase_offset;
    p_d = ps[PHASE_W-1 -: KW];
    sel_d = wave_sel;
    duty_d = duty;
    amp1_d = amp;
    amp2_d = amp1_q;
    u = p_q[KW-1 -: OUT_W];
    quad = p_q[KW-1 -: 2];
    idx = quad[0] ? ~p_q[KW-3 -: LUT_AW] : p_q[KW-3 -: LUT_AW];
    mag = rom[idx];
    sine = quad[1] ? -mag : mag;
    saw = u ^ MSB;
    t = u[OUT_W-1] ? ~u[OUT_W-2:0] : u[OUT_W-2:0];
    tri_w = {t, 1'b0} ^ MSB;
    rect = (u < duty_q) ? POS : NEG;
    raw_d = (sel_q == 3'd0) ? sine :
            (sel_q == 3'd1) ? saw :
            (sel_q == 3'd2) ? ~saw :
            (sel_q == 3'd3) ? tri_w :
            (sel_q == 3'd4) ? rect : '0;
    prod = $signed(raw_q) * $signed({1'b0, amp2_q});
    y = prod >>> (AMP_W - 1);
    wave_d = (y > Y_MAX) ? POS : (y < Y_MIN) ? MSB : y[OUT_W-1:0];
    vld_d = {vld_q[1:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      tw_active_q <= '0;
      tw_pending_q <= '0;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
      p_q <= '0;
      sel_q <= '0;
      duty_q <= '0;
      amp1_q <= '0;
      amp2_q <= '0;
      raw_q <= '0;
      wave_q <= '0;
      vld_q <= '0;
    end else begin
      acc_q <= acc_d;
      tw_active_q <= tw_active_d;
      tw_pending_q <= tw_pending_d;
      pend_q <= pend_d;
      wrap_q <= wrap_d;
      p_q <= p_d;
      sel_q <= sel_d;
      duty_q <= duty_d;
      amp1_q <= amp1_d;
      amp2_q <= amp2_d;
      raw_q <= raw_d;
      wave_q <= wave_d;
      vld_q <= vld_d;
    end
  end

  assign wave_o = wave_q;
  assign valid_o = vld_q[2];
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: scenario tasks plus randomized traffic, checked against a phase-level reference model.
module tb_dds_wave_gen;
  logic        clk = 0, rst_n = 0, halt = 0, phase_sync = 0, tune_load = 0;
  logic [31:0] tune_word = 0, phase_offset = 0;
  logic [2:0]  wave_sel = 0;
  logic [15:0] duty = 0, amp = 16'h8000;
  logic [15:0] wave_o;
  logic        valid_o, wrap_o;
  int checks = 0, passed = 0;

  logic [31:0] m_acc, m_tw, m_pend;
  bit          m_pf, m_wrap;
  int          m_edges;
  int          m_hist [3];

  always #5 clk = ~clk;

  dds_wave_gen #(.PHASE_W(32), .OUT_W(16), .LUT_AW(8), .AMP_W(16), .APPLY_AT_WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .phase_sync(phase_sync), .tune_load(tune_load),
    .tune_word(tune_word), .phase_offset(phase_offset), .wave_sel(wave_sel), .duty(duty),
    .amp(amp), .wave_o(wave_o), .valid_o(valid_o), .wrap_o(wrap_o)
  );

  function automatic int sine_ref(logic [31:0] p);
    int q = int'(p[31:30]);
    int a = int'(p[29:22]);
    int i = (q % 2 == 1) ? 255 - a : a;
    int mag = $rtoi(32767.0 * $sin(3.14159265358979 * (i + 0.5) / 512.0) + 0.5);
    return (q >= 2) ? -mag : mag;
  endfunction

  function automatic int sample(logic [31:0] p, logic [2:0] sel, int d, int g);
    int u = int'(p[31:16]);
    int raw, tt;
    longint y;
    case (sel)
      3'd0: raw = sine_ref(p);
      3'd1: raw = u - 32768;
      3'd2: raw = 32767 - u;
      3'd3: begin tt = (u >= 32768) ? 65535 - u : u; raw = 2 * tt - 32768; end
      3'd4: raw = (u < d) ? 32767 : -32767;
      default: raw = 0;
    endcase
    y = (longint'(raw) * g) >>> 15;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic mreset();
    m_acc = 0; m_tw = 0; m_pend = 0; m_pf = 0; m_wrap = 0; m_edges = 0;
    m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
  endtask

  task automatic tick();
    logic [32:0] s;
    logic [31:0] nacc;
    bit c, ap;
    @(posedge clk);
    c = 0;
    nacc = m_acc;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = sample(m_acc + phase_offset, wave_sel, int'(duty), int'(amp));
    if (phase_sync) nacc = 0;
    else if (!halt) begin
      s = {1'b0, m_acc} + {1'b0, m_tw};
      c = s[32];
      nacc = s[31:0];
    end
    ap = m_pf && (m_tw == 0 || phase_sync || c);
    if (ap) m_tw = m_pend;
    if (tune_load) begin m_pend = tune_word; m_pf = 1; end
    else if (ap) m_pf = 0;
    m_wrap = c;
    m_acc = nacc;
    if (m_edges < 3) m_edges++;
    #1;
  endtask

  task automatic test_reset();
    mreset();
    #12;
    checks++; if (wave_o !== 16'd0) $display("FAIL reset_wave: got %0d want 0", wave_o); else passed++;
    checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
    checks++; if (wrap_o !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap_o); else passed++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_saw_retune();
    int wraps[$];
    wave_sel = 1; tune_word = 32'h1000_0000; tune_load = 1;
    for (int i = 0; i < 70; i++) begin
      tick();
      tune_load = 0;
      checks++;
      if (int'($signed(wave_o)) != m_hist[2] || wrap_o !== m_wrap || valid_o !== (m_edges >= 3))
        $display("FAIL saw_retune[%0d]: wave=%0d wrap=%b valid=%b want %0d %b %b", i,
                 $signed(wave_o), wrap_o, valid_o, m_hist[2], m_wrap, m_edges >= 3);
      else passed++;
      if (wrap_o) wraps.push_back(i);
      if (i == 40) begin tune_word = 32'h2000_0000; tune_load = 1; end
    end
    checks++;
    if (wraps.size() < 4 || wraps[1] - wraps[0] != 16 || wraps[wraps.size()-1] - wraps[wraps.size()-2] != 8)
      $display("FAIL wrap_spacing: got %0d wraps, spacing not 16 then 8", wraps.size());
    else passed++;
  endtask

  task automatic test_rect();
    int highs = 0;
    wave_sel = 4; duty = 16'h4000; tune_word = 32'h1000_0000; tune_load = 1;
    for (int i = 0; i < 52; i++) begin
      tick();
      tune_load = 0;
      checks++;
      if (int'($signed(wave_o)) != m_hist[2] || wrap_o !== m_wrap)
        $display("FAIL rect[%0d]: wave=%0d wrap=%b want %0d %b", i, $signed(wave_o), wrap_o, m_hist[2], m_wrap);
      else passed++;
      if (i >= 20 && int'($signed(wave_o)) == 32767) highs++;
    end
    checks++; if (highs != 8) $display("FAIL rect_duty: high samples %0d want 8", highs); else passed++;
    duty = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (int'($signed(wave_o)) != m_hist[2])
        $display("FAIL rect_duty0[%0d]: wave=%0d want %0d", i, $signed(wave_o), m_hist[2]);
      else passed++;
    end
    checks++; if (int'($signed(wave_o)) != -32767) $display("FAIL rect_low: got %0d want -32767", $signed(wave_o)); else passed++;
  endtask

  task automatic test_sine();
    int sv [300];
    int mx = -99999, mn = 99999, bad = 0;
    wave_sel = 0; tune_word = 32'h0100_0000; tune_load = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      tune_load = 0;
      sv[i] = int'($signed(wave_o));
      checks++;
      if (sv[i] != m_hist[2]) $display("FAIL sine[%0d]: wave=%0d want %0d", i, sv[i], m_hist[2]);
      else passed++;
      if (i >= 30) begin
        if (sv[i] > mx) mx = sv[i];
        if (sv[i] < mn) mn = sv[i];
      end
    end
    checks++; if (mx != 32767 || mn != -32767) $display("FAIL sine_peak: max=%0d min=%0d want 32767/-32767", mx, mn); else passed++;
    for (int i = 30; i < 160; i++) if (sv[i] != -sv[i+128]) bad++;
    checks++; if (bad != 0) $display("FAIL sine_odd: %0d asymmetric pairs want 0", bad); else passed++;
    phase_offset = 32'h4000_0000;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (int'($signed(wave_o)) != m_hist[2]) $display("FAIL cosine[%0d]: wave=%0d want %0d", i, $signed(wave_o), m_hist[2]);
      else passed++;
    end
    phase_offset = 0;
  endtask

  task automatic test_gain();
    int mx, mn;
    wave_sel = 1; tune_word = 32'h1000_0000; tune_load = 1;
    tick();
    tune_load = 0; phase_sync = 1;
    tick();
    phase_sync = 0; amp = 16'hFFFF; mx = -99999; mn = 99999;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (int'($signed(wave_o)) != m_hist[2]) $display("FAIL gain_max[%0d]: wave=%0d want %0d", i, $signed(wave_o), m_hist[2]);
      else passed++;
      if (int'($signed(wave_o)) > mx) mx = int'($signed(wave_o));
      if (int'($signed(wave_o)) < mn) mn = int'($signed(wave_o));
    end
    checks++; if (mx != 32767 || mn != -32768) $display("FAIL gain_clip: max=%0d min=%0d want 32767/-32768", mx, mn); else passed++;
    amp = 0;
    repeat (6) tick();
    checks++; if (wave_o !== 16'd0) $display("FAIL gain_zero: got %0d want 0", $signed(wave_o)); else passed++;
    amp = 16'h4000; mx = -99999; mn = 99999;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (int'($signed(wave_o)) != m_hist[2]) $display("FAIL gain_half[%0d]: wave=%0d want %0d", i, $signed(wave_o), m_hist[2]);
      else passed++;
      if (i >= 3) begin
        if (int'($signed(wave_o)) > mx) mx = int'($signed(wave_o));
        if (int'($signed(wave_o)) < mn) mn = int'($signed(wave_o));
      end
    end
    checks++; if (mx != 14336 || mn != -16384) $display("FAIL gain_range: max=%0d min=%0d want 14336/-16384", mx, mn); else passed++;
    amp = 16'h8000;
  endtask

  task automatic test_halt_sync();
    int held = 0;
    halt = 1; tune_word = 32'h2000_0000; tune_load = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tune_load = 0;
      checks++;
      if (int'($signed(wave_o)) != m_hist[2] || wrap_o !== 1'b0 || wrap_o !== m_wrap)
        $display("FAIL halt[%0d]: wave=%0d wrap=%b want %0d 0", i, $signed(wave_o), wrap_o, m_hist[2]);
      else passed++;
      if (i == 2) held = int'($signed(wave_o));
      if (i >= 3) begin
        checks++;
        if (int'($signed(wave_o)) != held) $display("FAIL halt_hold[%0d]: wave=%0d want %0d", i, $signed(wave_o), held);
        else passed++;
      end
    end
    halt = 0; phase_sync = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      phase_sync = 0;
      checks++;
      if (int'($signed(wave_o)) != m_hist[2] || wrap_o !== m_wrap)
        $display("FAIL sync[%0d]: wave=%0d wrap=%b want %0d %b", i, $signed(wave_o), wrap_o, m_hist[2], m_wrap);
      else passed++;
      if (i == 3) begin
        checks++;
        if (int'($signed(wave_o)) != -32768) $display("FAIL sync_zero: wave=%0d want -32768", $signed(wave_o));
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    tune_word = 32'h3000_0000; tune_load = 1;
    tick();
    tune_load = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (wave_o !== 16'd0 || valid_o !== 1'b0 || wrap_o !== 1'b0)
      $display("FAIL async_reset: wave=%0d valid=%b wrap=%b want 0 0 0", wave_o, valid_o, wrap_o);
    else passed++;
    mreset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (int'($signed(wave_o)) != m_hist[2] || wrap_o !== m_wrap || valid_o !== (m_edges >= 3))
        $display("FAIL post_reset[%0d]: wave=%0d wrap=%b valid=%b want %0d %b %b", i,
                 $signed(wave_o), wrap_o, valid_o, m_hist[2], m_wrap, m_edges >= 3);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      halt = ($urandom_range(0, 7) == 0);
      phase_sync = ($urandom_range(0, 15) == 0);
      tune_load = ($urandom_range(0, 7) == 0);
      tune_word = $urandom;
      phase_offset = $urandom;
      wave_sel = 3'($urandom_range(0, 7));
      duty = 16'($urandom);
      amp = 16'($urandom);
      tick();
      checks++;
      if (int'($signed(wave_o)) != m_hist[2] || wrap_o !== m_wrap || valid_o !== (m_edges >= 3))
        $display("FAIL random[%0d]: wave=%0d wrap=%b valid=%b want %0d %b %b", i,
                 $signed(wave_o), wrap_o, valid_o, m_hist[2], m_wrap, m_edges >= 3);
      else passed++;
    end
    halt = 0; phase_sync = 0; tune_load = 0;
  endtask

  initial begin
    test_reset();
    test_saw_retune();
    test_rect();
    test_sine();
    test_gain();
    test_halt_sync();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
